line_sp_list: RTL and testbench

- Per-scanline sprite list between the mode-2 OAM scan and the mode-3 sprite fetcher.
- Write side: during OAM scan, captures up to 10 hitting sprites as (sprite number, fine Y, X).
- Read side: during pixel transfer, compares the pixel pipeline's X against stored entries and issues fetch requests to the sprite fetcher with a req/ack handshake.
- Stalls the pixel pipeline while a fetch is pending.

---
 rtl/ppu_pkg.sv | 26 ++
 rtl/line_sp_match.sv | 37 +++
 rtl/line_sp_list.sv | 162 ++++++++++++++++
 tb/tb_line_sp_list.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: definitions shared by the PPU per-scanline sprite logic.
//   - PPU mode encodings used by the sprite list (OAM scan, pixel transfer)
//   - MAX_LINE_SP: DMG hardware limit of sprites per scanline
//   - line_sp_entry_t: one stored sprite hit {sp_num, fine_y, x}
//   - sp_state_t: read-side fetch FSM states
package ppu_pkg;

  localparam logic [1:0] PPU_MODE_OAM  = 2'd2;
  localparam logic [1:0] PPU_MODE_XFER = 2'd3;

  localparam int MAX_LINE_SP = 10;
  localparam int SP_IDX_W    = 4;   // enough to index MAX_LINE_SP entries
  localparam int SP_CNT_W    = 4;   // holds 0..MAX_LINE_SP

  typedef struct packed {
    logic [5:0] sp_num;
    logic [3:0] fine_y;
    logic [7:0] x;
  } line_sp_entry_t;

  typedef enum logic {
    SP_SEARCH = 1'b0,
    SP_REQ    = 1'b1
  } sp_state_t;

endpackage

// File: rtl/line_sp_match.sv
// line_sp_match: combinational lowest-index priority matcher.
// Finds the lowest entry index whose candidate bit is set and whose X
// equals the pipeline X.
// Ports:
//   cand    in  N      per-entry candidate (stored and not yet fetched)
//   entries in  N x    stored sprite entries
//   lx      in  X_W    pipeline X in OAM coordinates
//   hit     out 1      at least one candidate matches
//   idx     out IDX_W  lowest matching index (0 when no hit)
module line_sp_match
  import ppu_pkg::*;
#(
  parameter int N     = MAX_LINE_SP,
  parameter int X_W   = 8,
  parameter int IDX_W = SP_IDX_W
) (
  input  logic [N-1:0]     cand,
  input  line_sp_entry_t   entries [N],
  input  logic [X_W-1:0]   lx,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest matching index is written last
  // and therefore wins; that gives OAM order for sprites sharing an X.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i] && (entries[i].x == lx)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/line_sp_list.sv
// line_sp_list: per-scanline sprite list between OAM scan and the sprite
// fetcher.
// Write side (mode 2): captures up to MAX_SP hitting sprites in arrival
// order. Entering mode 2 clears the list; a write on that same cycle is
// kept as entry 0.
// Read side (mode 3, sprites enabled): when the pipeline presents an X that
// matches an unfetched entry, the lowest such entry is latched into the
// fetch outputs and a request is raised while the pipeline is stalled.
//
// Handshake: fetch_req is a valid-style request; while it is high,
// fetch_sp_num/fetch_fine_y are held stable. A cycle with fetch_req and
// fetch_ack both high completes the transfer, marks the entry consumed and
// drops fetch_req on the next cycle. fetch_ack without fetch_req is ignored.
// Leaving mode 3 or clearing sp_enable while requesting withdraws the
// request next cycle without consuming the entry.
//
// Ports:
//   clk, n_rst         clock, async active-low reset
//   mode               PPU mode (2 OAM scan, 3 pixel transfer)
//   sp_enable          LCDC sprite enable
//   list_write         store {sp_num, fine_y, sp_x} (mode 2 only)
//   sp_num/fine_y/sp_x sprite being written
//   lx, lx_valid       pipeline X and its valid strobe
//   fetch_req          request to the sprite fetcher
//   fetch_sp_num/fine_y  sprite to fetch, stable while fetch_req
//   fetch_ack          fetcher done with current request
//   sp_stall           freeze the pixel pipeline
//   sp_count           entries stored this line (0..MAX_SP)
//   fsm_state          read-side FSM state, for observation
module line_sp_list
  import ppu_pkg::*;
#(
  parameter int MAX_SP = MAX_LINE_SP,
  parameter int X_W    = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [1:0]          mode,
  input  logic                sp_enable,
  input  logic                list_write,
  input  logic [5:0]          sp_num,
  input  logic [3:0]          fine_y,
  input  logic [X_W-1:0]      sp_x,
  input  logic [X_W-1:0]      lx,
  input  logic                lx_valid,
  output logic                fetch_req,
  output logic [5:0]          fetch_sp_num,
  output logic [3:0]          fetch_fine_y,
  input  logic                fetch_ack,
  output logic                sp_stall,
  output logic [SP_CNT_W-1:0] sp_count,
  output sp_state_t           fsm_state
);

  logic [1:0]          mode_q;
  logic [SP_CNT_W-1:0] count;
  logic [MAX_SP-1:0]   valid;
  logic [MAX_SP-1:0]   consumed;
  line_sp_entry_t      entries [MAX_SP];
  logic [SP_IDX_W-1:0] fetch_idx;
  sp_state_t           state;
  sp_state_t           state_next;

  logic                clear;
  logic                wr_en;
  logic                xfer_en;
  logic                hit;
  logic [SP_IDX_W-1:0] hit_idx;
  logic                take;
  logic                consume;
  line_sp_entry_t      wr_entry;

  assign clear    = (mode_q != PPU_MODE_OAM) && (mode == PPU_MODE_OAM);
  assign wr_en    = list_write && (mode == PPU_MODE_OAM);
  assign xfer_en  = (mode == PPU_MODE_XFER) && sp_enable;
  assign wr_entry = '{sp_num: sp_num, fine_y: fine_y, x: 8'(sp_x)};

  line_sp_match #(
    .N     (MAX_SP),
    .X_W   (X_W),
    .IDX_W (SP_IDX_W)
  ) u_match (
    .cand    (valid & ~consumed),
    .entries (entries),
    .lx      (lx),
    .hit     (hit),
    .idx     (hit_idx)
  );

  // A match only launches a fetch while searching with a live pixel.
  assign take    = (state == SP_SEARCH) && xfer_en && hit && lx_valid;
  assign consume = (state == SP_REQ) && fetch_ack;

  // List storage: clear on entry into mode 2, append otherwise.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q   <= '0;
      count    <= '0;
      valid    <= '0;
      consumed <= '0;
      for (int i = 0; i < MAX_SP; i++) begin
        entries[i] <= '0;
      end
    end else begin
      mode_q <= mode;
      if (clear) begin
        valid    <= '0;
        consumed <= '0;
        count    <= wr_en ? SP_CNT_W'(1) : '0;
        if (wr_en) begin
          entries[0] <= wr_entry;
          valid[0]   <= 1'b1;
        end
      end else begin
        if (wr_en && (count < SP_CNT_W'(MAX_SP))) begin
          entries[count] <= wr_entry;
          valid[count]   <= 1'b1;
          count          <= count + SP_CNT_W'(1);
        end
        if (consume) begin
          consumed[fetch_idx] <= 1'b1;
        end
      end
    end
  end

  // Fetch FSM: state register and latched request payload.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= SP_SEARCH;
      fetch_idx    <= '0;
      fetch_sp_num <= '0;
      fetch_fine_y <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        fetch_idx    <= hit_idx;
        fetch_sp_num <= entries[hit_idx].sp_num;
        fetch_fine_y <= entries[hit_idx].fine_y;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SP_SEARCH: if (take) state_next = SP_REQ;
      // An ack completes the fetch even if the mode changes on the same
      // cycle; otherwise losing mode 3 or sp_enable withdraws the request.
      SP_REQ:    if (fetch_ack || !xfer_en) state_next = SP_SEARCH;
      default:   state_next = SP_SEARCH;
    endcase
  end

  // The stall covers the match cycle itself so the pipeline holds at lx
  // before the request is even visible.
  assign fetch_req = (state == SP_REQ);
  assign sp_stall  = fetch_req || take;
  assign sp_count  = count;
  assign fsm_state = state;

endmodule

// File: tb/tb_line_sp_list.sv
module tb_line_sp_list;
  import ppu_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       sp_enable = 1'b1;
  logic       list_write = 1'b0;
  logic [5:0] sp_num = '0;
  logic [3:0] fine_y = '0;
  logic [7:0] sp_x = '0;
  logic [7:0] lx = '0;
  logic       lx_valid = 1'b0;
  logic       fetch_req;
  logic [5:0] fetch_sp_num;
  logic [3:0] fetch_fine_y;
  logic       fetch_ack = 1'b0;
  logic       sp_stall;
  logic [3:0] sp_count;
  sp_state_t  fsm_state;

  always #5 clk = ~clk;

  line_sp_list dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .mode         (mode),
    .sp_enable    (sp_enable),
    .list_write   (list_write),
    .sp_num       (sp_num),
    .fine_y       (fine_y),
    .sp_x         (sp_x),
    .lx           (lx),
    .lx_valid     (lx_valid),
    .fetch_req    (fetch_req),
    .fetch_sp_num (fetch_sp_num),
    .fetch_fine_y (fetch_fine_y),
    .fetch_ack    (fetch_ack),
    .sp_stall     (sp_stall),
    .sp_count     (sp_count),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The line is a list of sprites in write order; entries at index >= m_cnt
  // do not exist. m_pend means a fetch of entry m_pi is outstanding.
  int m_sp [10];
  int m_fy [10];
  int m_x  [10];
  bit m_cons [10];
  int m_cnt, m_prev, m_pend, m_pi, m_osp, m_ofy;

  task automatic model_reset();
    m_cnt = 0; m_prev = 0; m_pend = 0; m_pi = 0; m_osp = 0; m_ofy = 0;
    for (int i = 0; i < 10; i++) begin
      m_sp[i] = 0; m_fy[i] = 0; m_x[i] = 0; m_cons[i] = 1'b0;
    end
  endtask

  initial model_reset();

  // Compare process: inputs only change just after posedge, so at negedge
  // they are exactly what the next posedge will see.
  always @(negedge clk) begin : compare
    int  hi;
    bit  active;
    if (!n_rst) model_reset();
    hi = -1;
    active = (m_pend == 0) && (mode == 2'd3) && sp_enable;
    if (active) begin
      for (int i = 0; i < m_cnt; i++) begin
        if (!m_cons[i] && m_x[i] == int'(lx)) begin
          hi = i;
          break;
        end
      end
    end
    chk("cyc_req",   {31'd0, fetch_req}, (m_pend != 0) ? 32'd1 : 32'd0);
    chk("cyc_stall", {31'd0, sp_stall},
        ((m_pend != 0) || (hi >= 0 && lx_valid)) ? 32'd1 : 32'd0);
    chk("cyc_count", {28'd0, sp_count}, m_cnt);
    chk("cyc_sp",    {26'd0, fetch_sp_num}, m_osp);
    chk("cyc_fy",    {28'd0, fetch_fine_y}, m_ofy);
    if (n_rst) begin
      if (m_pend != 0) begin
        if (fetch_ack) begin
          m_cons[m_pi] = 1'b1;
          m_pend = 0;
        end else if (mode != 2'd3 || !sp_enable) begin
          m_pend = 0;
        end
      end else if (hi >= 0 && lx_valid) begin
        m_pend = 1; m_pi = hi; m_osp = m_sp[hi]; m_ofy = m_fy[hi];
      end
      if (m_prev != 2 && mode == 2'd2) begin
        m_cnt = 0;
        for (int i = 0; i < 10; i++) m_cons[i] = 1'b0;
      end
      if (list_write && mode == 2'd2 && m_cnt < 10) begin
        m_sp[m_cnt] = int'(sp_num);
        m_fy[m_cnt] = int'(fine_y);
        m_x[m_cnt]  = int'(sp_x);
        m_cons[m_cnt] = 1'b0;
        m_cnt++;
      end
      m_prev = int'(mode);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line();
    list_write = 1'b0;
    mode = 2'd0;
    tick();
    mode = 2'd2;
  endtask

  task automatic wr(input int n, input int fy, input int x);
    sp_num = 6'(n); fine_y = 4'(fy); sp_x = 8'(x);
    list_write = 1'b1;
    tick();
    list_write = 1'b0;
  endtask

  task automatic ack_once();
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
  endtask

  int got_q[$];

  // Sweep lx over [lo, hi], servicing every request with a random ack delay.
  task automatic sweep(input int lo, input int hi, output int nreq);
    nreq = 0;
    for (int x = lo; x <= hi; x++) begin
      lx = 8'(x);
      lx_valid = 1'b1;
      tick();
      for (int g = 0; g < 40 && fetch_req; g++) begin
        got_q.push_back(int'(fetch_sp_num));
        nreq++;
        repeat ($urandom_range(0, 3)) tick();
        ack_once();
        tick();
      end
    end
    lx_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int seen_hi;
    repeat (3) tick();
    chk("rst_count", {28'd0, sp_count}, 0);
    chk("rst_req",   {31'd0, fetch_req}, 0);
    n_rst = 1'b1;
    tick();

    // Reset in the middle of a request.
    start_line();
    wr(5, 3, 20);
    mode = 2'd3; sp_enable = 1'b1; lx = 8'd20; lx_valid = 1'b1;
    #1;
    chk("midreq_stall_match", {31'd0, sp_stall}, 1);
    tick();
    chk("midreq_req", {31'd0, fetch_req}, 1);
    chk("midreq_sp",  {26'd0, fetch_sp_num}, 5);
    chk("midreq_fy",  {28'd0, fetch_fine_y}, 3);
    n_rst = 1'b0;
    #1;
    chk("midreq_rst_req",   {31'd0, fetch_req}, 0);
    chk("midreq_rst_stall", {31'd0, sp_stall}, 0);
    chk("midreq_rst_count", {28'd0, sp_count}, 0);
    lx_valid = 1'b0; mode = 2'd0;
    tick();
    n_rst = 1'b1;
    tick();

    // Overflow: only the first ten writes are kept.
    start_line();
    for (int i = 0; i < 12; i++) wr(i, i, 30 + 4 * i);
    chk("ovf_count", {28'd0, sp_count}, 10);
    mode = 2'd3;
    got_q.delete();
    sweep(8, 167, n);
    chk("ovf_nreq", n, 10);
    seen_hi = 0;
    foreach (got_q[k]) if (got_q[k] >= 10) seen_hi++;
    chk("ovf_dropped_never_fetched", seen_hi, 0);

    // Two sprites at the same X are fetched in OAM (write) order.
    start_line();
    wr(7, 1, 40);
    wr(2, 4, 40);
    mode = 2'd3; lx = 8'd40; lx_valid = 1'b1;
    #1;
    chk("samex_stall0", {31'd0, sp_stall}, 1);
    tick();
    chk("samex_req1", {31'd0, fetch_req}, 1);
    chk("samex_sp1",  {26'd0, fetch_sp_num}, 7);
    chk("samex_fy1",  {28'd0, fetch_fine_y}, 1);
    ack_once();
    chk("samex_req_drop", {31'd0, fetch_req}, 0);
    chk("samex_restall",  {31'd0, sp_stall}, 1);
    tick();
    chk("samex_sp2", {26'd0, fetch_sp_num}, 2);
    chk("samex_fy2", {28'd0, fetch_fine_y}, 4);
    ack_once();
    chk("samex_done_stall", {31'd0, sp_stall}, 0);
    lx_valid = 1'b0;

    // Request held stable across a delayed ack, then never repeated.
    start_line();
    wr(3, 9, 60);
    mode = 2'd3; lx = 8'd60; lx_valid = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      chk("hold_req", {31'd0, fetch_req}, 1);
      chk("hold_sp",  {26'd0, fetch_sp_num}, 3);
      chk("hold_fy",  {28'd0, fetch_fine_y}, 9);
      tick();
    end
    ack_once();
    for (int c = 0; c < 4; c++) begin
      chk("hold_consumed_req",   {31'd0, fetch_req}, 0);
      chk("hold_consumed_stall", {31'd0, sp_stall}, 0);
      tick();
    end
    lx_valid = 1'b0;

    // Offscreen entry at x=0 counts but never matches.
    start_line();
    wr(1, 0, 0);
    chk("offscr_count", {28'd0, sp_count}, 1);
    mode = 2'd3;
    sweep(8, 167, n);
    chk("offscr_nreq", n, 0);

    // Sprites disabled: no request, no stall.
    start_line();
    wr(4, 2, 50);
    mode = 2'd3; sp_enable = 1'b0; lx = 8'd50; lx_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("dis_req",   {31'd0, fetch_req}, 0);
      chk("dis_stall", {31'd0, sp_stall}, 0);
    end
    sp_enable = 1'b1;
    #1;
    chk("en_stall", {31'd0, sp_stall}, 1);
    tick();
    chk("en_sp", {26'd0, fetch_sp_num}, 4);
    ack_once();
    lx_valid = 1'b0;

    // Line clear, then line clear with a simultaneous write.
    mode = 2'd0; tick();
    mode = 2'd2; tick();
    chk("clear_count0", {28'd0, sp_count}, 0);
    mode = 2'd3; tick();
    mode = 2'd0; tick();
    mode = 2'd2;
    wr(9, 5, 77);
    chk("clear_wr_count1", {28'd0, sp_count}, 1);
    mode = 2'd3; lx = 8'd77; lx_valid = 1'b1;
    tick();
    chk("clear_wr_req", {31'd0, fetch_req}, 1);
    chk("clear_wr_sp",  {26'd0, fetch_sp_num}, 9);
    chk("clear_wr_fy",  {28'd0, fetch_fine_y}, 5);
    ack_once();
    lx_valid = 1'b0;

    // Randomized lines checked cycle by cycle against the model.
    for (int l = 0; l < 25; l++) begin
      start_line();
      n = $urandom_range(0, 13);
      for (int k = 0; k < n; k++)
        wr($urandom_range(0, 39), $urandom_range(0, 15), $urandom_range(0, 45));
      for (int c = 0; c < 120; c++) begin
        sp_enable  = ($urandom_range(0, 15) != 0);
        mode       = ($urandom_range(0, 29) == 0) ? 2'd0 : 2'd3;
        lx_valid   = 1'($urandom_range(0, 1));
        if (!sp_stall) lx = 8'($urandom_range(6, 44));
        list_write = ($urandom_range(0, 7) == 0);
        sp_num = 6'($urandom_range(0, 63)); sp_x = 8'($urandom_range(8, 44));
        fetch_ack  = fetch_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        tick();
      end
      list_write = 1'b0; fetch_ack = 1'b0; lx_valid = 1'b0; sp_enable = 1'b1;
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
